// File: rtl/mod_engine.sv
// Two-oscillator modulation engine: single-cycle combine modes plus a
// sequential shift-add ring modulator (mode 011) taking M cycles.
module mod_engine #(
  parameter int M = 12,
  parameter int O = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [M-1:0] osc0,
  input  logic [M-1:0] osc1,
  input  logic [2:0]   modulation_select,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [O-1:0] modulation_out,
  output logic         out_valid
);

  localparam int SH = O - M;
  localparam int CW = $clog2(M + 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t         state_reg, state_next;
  logic [M-1:0]   a_reg;
  logic [2*M-1:0] prod_reg, prod_next;
  logic [CW-1:0]  step_reg;
  logic [O-1:0]   out_reg;
  logic           out_valid_reg;

  logic           accept;
  logic           mul_done;
  logic [M:0]     add_sum;
  logic [M:0]     sum_full;
  logic [M-1:0]   avg, diff_avg, inv1, sat_sum;
  logic [O-1:0]   fill_mask;
  logic [O-1:0]   mode_result;

  // Ones mask over the LSBs that sit below a left-aligned M-bit value.
  for (genvar gi = 0; gi < O; gi++) begin : g_fill
    assign fill_mask[gi] = (gi < SH);
  end

  function automatic logic [O-1:0] align(input logic [M-1:0] v);
    return O'(v) << SH;
  endfunction

  assign accept   = in_valid && (state_reg == IDLE);
  assign mul_done = (state_reg == MUL) && (step_reg == CW'(M - 1));

  assign in_ready       = (state_reg == IDLE);
  assign modulation_out = out_reg;
  assign out_valid      = out_valid_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept && modulation_select == 3'b011) state_next = MUL;
      MUL:  if (mul_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // One shift-add step: add multiplicand into the high half when the
  // current multiplier LSB is set, then shift the whole product right.
  always_comb begin
    add_sum   = {1'b0, prod_reg[2*M-1:M]} + (prod_reg[0] ? {1'b0, a_reg} : '0);
    prod_next = {add_sum, prod_reg[M-1:1]};
  end

  always_comb begin
    inv1     = ~osc1;
    avg      = (osc0 >> 1) + (osc1 >> 1);
    diff_avg = (osc0 >> 1) + (inv1 >> 1);
    sum_full = {1'b0, osc0} + {1'b0, osc1};
    sat_sum  = sum_full[M] ? '1 : sum_full[M-1:0];
    mode_result = '0;
    case (modulation_select)
      3'b000:  mode_result = align(avg);
      3'b001:  mode_result = align(diff_avg) | fill_mask;
      3'b010:  mode_result = align(sat_sum);
      3'b100:  mode_result = align(osc0);
      3'b101:  mode_result = align(osc1);
      3'b110:  mode_result = align(osc0 ^ osc1);
      3'b111:  mode_result = align(osc0 & osc1);
      default: mode_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg         <= '0;
      prod_reg      <= '0;
      step_reg      <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      if (accept) begin
        if (modulation_select == 3'b011) begin
          a_reg    <= osc0;
          prod_reg <= {{M{1'b0}}, osc1};
          step_reg <= '0;
        end else begin
          out_reg       <= mode_result;
          out_valid_reg <= 1'b1;
        end
      end else if (state_reg == MUL) begin
        prod_reg <= prod_next;
        if (mul_done) begin
          step_reg      <= '0;
          out_reg       <= prod_next[2*M-1 -: O];
          out_valid_reg <= 1'b1;
        end else begin
          step_reg <= step_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mod_engine.sv
// Directed-vector bench for mod_engine at M=12, O=16.
module tb_mod_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] osc0, osc1;
  logic [2:0]  modulation_select;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] modulation_out;
  logic        out_valid;

  int vectors = 0;
  int miscompares = 0;

  mod_engine #(.M(12), .O(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .osc0(osc0),
    .osc1(osc1),
    .modulation_select(modulation_select),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .modulation_out(modulation_out),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [2:0] sel, input logic [11:0] a, input logic [11:0] b);
    modulation_select = sel;
    osc0 = a;
    osc1 = b;
    in_valid = 1'b1;
  endtask

  // Single-cycle mode table: select, osc0, osc1, expected output.
  logic [2:0]  t_sel [7];
  logic [11:0] t_a   [7];
  logic [11:0] t_b   [7];
  logic [15:0] t_exp [7];

  initial begin
    t_sel[0] = 3'b000; t_a[0] = 12'hFFF; t_b[0] = 12'hFFF; t_exp[0] = 16'hFFE0;
    t_sel[1] = 3'b001; t_a[1] = 12'h800; t_b[1] = 12'h000; t_exp[1] = 16'hBFFF;
    t_sel[2] = 3'b010; t_a[2] = 12'hC00; t_b[2] = 12'h800; t_exp[2] = 16'hFFF0;
    t_sel[3] = 3'b010; t_a[3] = 12'h100; t_b[3] = 12'h200; t_exp[3] = 16'h3000;
    t_sel[4] = 3'b100; t_a[4] = 12'h123; t_b[4] = 12'hABC; t_exp[4] = 16'h1230;
    t_sel[5] = 3'b101; t_a[5] = 12'h123; t_b[5] = 12'hABC; t_exp[5] = 16'hABC0;
    t_sel[6] = 3'b111; t_a[6] = 12'h123; t_b[6] = 12'hABC; t_exp[6] = 16'h0200;
  end

  initial begin
    int pulses;
    rst_n = 1'b0;
    in_valid = 1'b1;
    modulation_select = 3'b100;
    osc0 = 12'h555;
    osc1 = 12'h0;
    #2;
    check("reset out", modulation_out, 16'h0);
    check("reset valid", out_valid, 1'b0);
    tick();
    tick();
    check("no accept in reset", out_valid, 1'b0);
    check("no accept in reset out", modulation_out, 16'h0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("ready after reset", in_ready, 1'b1);

    // Average with a single in_valid cycle, then hold.
    offer(t_sel[0], t_a[0], t_b[0]);
    tick();
    check("avg out", modulation_out, t_exp[0]);
    check("avg valid", out_valid, 1'b1);
    in_valid = 1'b0;
    tick();
    check("avg pulse end", out_valid, 1'b0);
    check("avg hold", modulation_out, t_exp[0]);

    // Remaining single-cycle modes back to back.
    for (int i = 1; i < 7; i++) begin
      offer(t_sel[i], t_a[i], t_b[i]);
      tick();
      check($sformatf("mode%0d out v%0d", t_sel[i], i), modulation_out, t_exp[i]);
      check($sformatf("mode%0d valid v%0d", t_sel[i], i), out_valid, 1'b1);
    end

    // Ring mod 0xFFF*0xFFF while inputs churn during the busy period.
    offer(3'b011, 12'hFFF, 12'hFFF);
    tick();
    check("mul ready low", in_ready, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      offer(3'(i % 8 == 3 ? 4 : i % 8), 12'($urandom), 12'($urandom));
      if (i == 12) offer(3'b000, 12'h246, 12'h246);
      tick();
      if (i < 12) begin
        check($sformatf("mul busy ready s%0d", i), in_ready, 1'b0);
        check($sformatf("mul busy valid s%0d", i), out_valid, 1'b0);
        check($sformatf("mul busy hold s%0d", i), modulation_out, 16'h0200);
      end
    end
    check("mul result", modulation_out, 16'hFFE0);
    check("mul valid", out_valid, 1'b1);
    check("mul ready back", in_ready, 1'b1);
    tick();
    check("post-mul accept out", modulation_out, 16'h2460);
    check("post-mul accept valid", out_valid, 1'b1);

    // Second product exercises low-order multiplier bits.
    offer(3'b011, 12'h800, 12'h003);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    check("mul2 not yet", out_valid, 1'b0);
    tick();
    check("mul2 result", modulation_out, 16'h0018);
    check("mul2 valid", out_valid, 1'b1);

    // Abort a multiply at step 5 with a 2-cycle reset.
    offer(3'b011, 12'hFFF, 12'hFFF);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    #1;
    check("abort out", modulation_out, 16'h0);
    check("abort valid", out_valid, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    check("abort ready", in_ready, 1'b1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) pulses++;
    end
    check("abort no pulse", pulses, 0);
    check("abort out held", modulation_out, 16'h0);

    // XOR with in_valid held four cycles.
    for (int i = 0; i < 4; i++) begin
      offer(3'b110, 12'hAAA, 12'h555);
      tick();
      check($sformatf("xor out c%0d", i), modulation_out, 16'hFFF0);
      check($sformatf("xor valid c%0d", i), out_valid, 1'b1);
    end
    in_valid = 1'b0;
    tick();
    check("xor pulse end", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
